// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flop, processing WIDTH bits LSB first.
// The result and final carry are registered and announced with a one-cycle done pulse.
module bit_serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_carry_in,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry_out
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_c;
   logic [CW-1:0]    r_cnt;
   // Holds the upper WIDTH-1 bits of the sum shifter; the bit that would fall out is never needed.
   logic [WIDTH-2:0] r_sum_sh;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   logic             w_s;
   logic             w_co;
   logic             w_last;
   logic             w_accept;
   logic [WIDTH-1:0] w_sum_fin;

   assign w_s       = r_a[0] ^ r_b[0] ^ r_c;
   assign w_co      = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
   assign w_last    = (r_cnt == CW'(WIDTH - 1));
   assign w_accept  = (r_state == S_IDLE) && i_start;
   assign w_sum_fin = {w_s, r_sum_sh};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last)  w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Status decoded from registered state only
   always_comb begin
      o_busy = 1'b0;
      o_done = 1'b0;
      case (r_state)
         S_RUN:   o_busy = 1'b1;
         S_DONE:  o_done = 1'b1;
         default: ;
      endcase
   end

   // Operand/carry/sum shifters and bit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_c      <= 1'b0;
         r_cnt    <= '0;
         r_sum_sh <= '0;
      end else if (w_accept) begin
         r_a   <= i_a;
         r_b   <= i_b;
         r_c   <= i_carry_in;
         r_cnt <= '0;
      end else if (r_state == S_RUN) begin
         r_a      <= {1'b0, r_a[WIDTH-1:1]};
         r_b      <= {1'b0, r_b[WIDTH-1:1]};
         r_c      <= w_co;
         r_cnt    <= r_cnt + CW'(1);
         r_sum_sh <= w_sum_fin[WIDTH-1:1];
      end
   end

   // Result registers change only on the last processed bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else if ((r_state == S_RUN) && w_last) begin
         r_sum  <= w_sum_fin;
         r_cout <= w_co;
      end
   end

   assign o_sum       = r_sum;
   assign o_carry_out = r_cout;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and random checks of bit_serial_adder at WIDTH=8 and WIDTH=13.
module tb_bit_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s8_start, s8_cin, s8_busy, s8_done, s8_cout;
   logic [7:0]  s8_a, s8_b, s8_sum;
   logic        s13_start, s13_cin, s13_busy, s13_done, s13_cout;
   logic [12:0] s13_a, s13_b, s13_sum;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bit_serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .i_start(s8_start), .i_a(s8_a), .i_b(s8_b),
      .i_carry_in(s8_cin), .o_busy(s8_busy), .o_done(s8_done), .o_sum(s8_sum),
      .o_carry_out(s8_cout)
   );

   bit_serial_adder #(.WIDTH(13)) u_dut13 (
      .clk(clk), .rst_n(rst_n), .i_start(s13_start), .i_a(s13_a), .i_b(s13_b),
      .i_carry_in(s13_cin), .o_busy(s13_busy), .o_done(s13_done), .o_sum(s13_sum),
      .o_carry_out(s13_cout)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [32:0] get_res(input int unsigned w);
      if (w == 8) return 33'({s8_cout, s8_sum});
      else        return 33'({s13_cout, s13_sum});
   endfunction

   function automatic logic get_busy(input int unsigned w);
      return (w == 8) ? s8_busy : s13_busy;
   endfunction

   function automatic logic get_done(input int unsigned w);
      return (w == 8) ? s8_done : s13_done;
   endfunction

   task automatic drive(input int unsigned w, input logic st, input logic [31:0] a,
                        input logic [31:0] b, input logic cin);
      if (w == 8) begin
         s8_start = st; s8_a = a[7:0]; s8_b = b[7:0]; s8_cin = cin;
      end else begin
         s13_start = st; s13_a = a[12:0]; s13_b = b[12:0]; s13_cin = cin;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation: accept, count busy cycles and latency, check result and hold.
   task automatic do_op(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input string tag);
      logic [32:0] exp;
      int          lat;
      int          busy_cnt;
      exp = 33'(a) + 33'(b) + 33'(cin);
      drive(w, 1'b1, a, b, cin);
      tick();
      drive(w, 1'b0, ~a, ~b, ~cin);
      lat      = 0;
      busy_cnt = 0;
      while (!get_done(w) && lat < 4 * int'(w)) begin
         if (get_busy(w)) busy_cnt++;
         tick();
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(w));
      check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(w));
      check({tag, " result"}, 64'(get_res(w)), 64'(exp));
      tick();
      check({tag, " done_falls"}, 64'({get_done(w), get_busy(w)}), 64'(0));
      check({tag, " result_hold"}, 64'(get_res(w)), 64'(exp));
   endtask

   initial begin
      int ndone;
      int last;
      int lowrun;
      logic [32:0] res;
      logic [31:0] ra, rb;

      rst_n = 1'b0;
      drive(8, 1'b0, 32'h0, 32'h0, 1'b0);
      drive(13, 1'b0, 32'h0, 32'h0, 1'b0);
      repeat (3) tick();
      check("reset_res8", 64'(get_res(8)), 64'(0));
      check("reset_stat8", 64'({s8_busy, s8_done}), 64'(0));
      check("reset_res13", 64'(get_res(13)), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      do_op(8, 32'h5A, 32'h3C, 1'b0, "add_5a_3c");
      do_op(8, 32'hFF, 32'h01, 1'b0, "add_ff_01");
      do_op(8, 32'hFF, 32'hFF, 1'b1, "add_ff_ff_c");
      do_op(13, 32'h1FFF, 32'h0001, 1'b0, "add13_wrap");

      // Start pulsed mid-run must be ignored
      drive(8, 1'b1, 32'h12, 32'h34, 1'b0);
      tick();
      drive(8, 1'b0, 32'h0, 32'h0, 1'b0);
      tick();
      tick();
      drive(8, 1'b1, 32'hFF, 32'hFF, 1'b1);
      tick();
      drive(8, 1'b0, 32'h0, 32'h0, 1'b0);
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         if (s8_done) ndone++;
         tick();
      end
      check("ignore_start_dones", 64'(ndone), 64'(1));
      check("ignore_start_result", 64'(get_res(8)), 64'(33'h046));
      check("ignore_start_idle", 64'(s8_busy), 64'(0));

      // Asynchronous reset on the 4th busy cycle
      drive(8, 1'b1, 32'h80, 32'h80, 1'b0);
      tick();
      drive(8, 1'b0, 32'h0, 32'h0, 1'b0);
      repeat (3) tick();
      check("pre_reset_busy", 64'(s8_busy), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      check("midrun_reset_stat", 64'({s8_busy, s8_done}), 64'(0));
      check("midrun_reset_res", 64'(get_res(8)), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (s8_done || s8_busy) ndone++;
      end
      check("post_reset_quiet", 64'(ndone), 64'(0));

      // start held high: one result per WIDTH+2 cycles, two idle/done cycles between runs
      drive(8, 1'b1, 32'h01, 32'h01, 1'b0);
      ndone  = 0;
      last   = -1;
      lowrun = 0;
      for (int cyc = 0; cyc < 45; cyc++) begin
         tick();
         if (s8_done) begin
            ndone++;
            check("cont_result", 64'(get_res(8)), 64'(33'h002));
            if (last >= 0) check("cont_period", 64'(cyc - last), 64'(10));
            last = cyc;
         end
         if (!s8_busy) lowrun++;
         else begin
            if (lowrun > 0) check("cont_busy_gap", 64'(lowrun), 64'(2));
            lowrun = 0;
         end
      end
      check("cont_done_count", 64'(ndone), 64'(4));
      drive(8, 1'b0, 32'h0, 32'h0, 1'b0);
      ndone = 0;
      while ((s8_busy || s8_done) && ndone < 30) begin
         tick();
         ndone++;
      end
      check("cont_drain", 64'({s8_busy, s8_done}), 64'(0));
      tick();

      for (int i = 0; i < 1000; i++) begin
         ra = $urandom & 32'hFF;
         rb = $urandom & 32'hFF;
         do_op(8, ra, rb, 1'($urandom), "rnd8");
      end
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom & 32'h1FFF;
         rb = $urandom & 32'h1FFF;
         do_op(13, ra, rb, 1'($urandom), "rnd13");
      end

      res = get_res(8);
      check("dut8_idle_end", 64'({s8_busy, s8_done}), 64'(0));
      if (res === 33'bx) failures++;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
